// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: upstream request ports and downstream controller bus.
// slave = arbiter side, master = masters plus controller side.
interface mem_req_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [N_PORTS*ADDR_W-1:0] up_addr;
  logic [N_PORTS-1:0]        up_wr_req;
  logic [N_PORTS-1:0]        up_rd_req;
  logic [N_PORTS*DATA_W-1:0] up_wdata;
  logic [N_PORTS*BE_W-1:0]   up_wr_byte_en;
  logic [N_PORTS-1:0]        up_busy;
  logic [N_PORTS-1:0]        up_rd_rdy;
  logic [DATA_W-1:0]         up_rdata;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_wr_req;
  logic                      mem_rd_req;
  logic [DATA_W-1:0]         mem_wdata;
  logic [BE_W-1:0]           mem_wr_byte_en;
  logic                      mem_busy;
  logic                      mem_rd_rdy;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      proto_err;

  modport slave (
    input  up_addr, up_wr_req, up_rd_req,
    input  up_wdata, up_wr_byte_en,
    input  mem_busy, mem_rd_rdy, mem_rdata,
    output up_busy, up_rd_rdy, up_rdata,
    output mem_addr, mem_wr_req, mem_rd_req,
    output mem_wdata, mem_wr_byte_en,
    output proto_err
  );

  modport master (
    output up_addr, up_wr_req, up_rd_req,
    output up_wdata, up_wr_byte_en,
    output mem_busy, mem_rd_rdy, mem_rdata,
    input  up_busy, up_rd_rdy, up_rdata,
    input  mem_addr, mem_wr_req, mem_rd_req,
    input  mem_wdata, mem_wr_byte_en,
    input  proto_err
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: N-port FIFO'd round-robin front end for one memory port.
// Ports: clk, reset (sync, high), bus (mem_req_arbiter_if.slave).
module mem_req_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RD     = 8
) (
  input  logic             clk,
  input  logic             reset,
  mem_req_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int PW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int FAW  = $clog2(FIFO_DEPTH);
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam int TAW  = $clog2(MAX_RD);
  localparam int TCW  = $clog2(MAX_RD + 1);

  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } cmd_t;

  typedef logic [PW-1:0] port_t;

  cmd_t               fifo_q [N_PORTS][FIFO_DEPTH];
  cmd_t               fifo_d [N_PORTS][FIFO_DEPTH];
  logic [FAW-1:0]     wptr_q [N_PORTS];
  logic [FAW-1:0]     wptr_d [N_PORTS];
  logic [FAW-1:0]     rptr_q [N_PORTS];
  logic [FAW-1:0]     rptr_d [N_PORTS];
  logic [FCW-1:0]     cnt_q  [N_PORTS];
  logic [FCW-1:0]     cnt_d  [N_PORTS];
  logic [N_PORTS-1:0] busy_q, busy_d;

  logic  out_vld_q, out_vld_d;
  cmd_t  out_q, out_d;
  port_t out_src_q, out_src_d;
  port_t rr_q, rr_d;

  port_t          tag_q [MAX_RD];
  port_t          tag_d [MAX_RD];
  logic [TAW-1:0] twp_q, twp_d;
  logic [TAW-1:0] trp_q, trp_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;

  logic [N_PORTS-1:0] rdy_q, rdy_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic           accept, load_ok, rd_ok;
  logic           win_vld, tpush, tpop;
  logic           push, pop, wr, rd;
  port_t          win;
  int             idx;
  logic [TCW-1:0] rd_infl;

  always_comb begin
    accept  = out_vld_q & ~bus.mem_busy;
    load_ok = ~out_vld_q | accept;
    // A read waiting in the output register already
    // owns a tag slot, so count it as outstanding.
    rd_infl = tcnt_q + TCW'(out_vld_q & ~out_q.is_wr);
    rd_ok   = rd_infl < TCW'(MAX_RD);

    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = (int'(rr_q) + i) % N_PORTS;
      if (!win_vld && cnt_q[idx] != '0 &&
          (fifo_q[idx][rptr_q[idx]].is_wr || rd_ok)) begin
        win_vld = 1'b1;
        win     = port_t'(idx);
      end
    end

    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    err_d  = err_q;
    push   = 1'b0;
    pop    = 1'b0;
    wr     = 1'b0;
    rd     = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      wr   = bus.up_wr_req[p];
      rd   = bus.up_rd_req[p];
      push = (wr | rd) & ~busy_q[p];
      pop  = load_ok & win_vld & (win == port_t'(p));
      if (wr & rd) err_d = 1'b1;
      if (push) begin
        fifo_d[p][wptr_q[p]] = {
          wr,
          bus.up_addr[p*ADDR_W +: ADDR_W],
          bus.up_wdata[p*DATA_W +: DATA_W],
          bus.up_wr_byte_en[p*BE_W +: BE_W]
        };
        wptr_d[p] = wptr_q[p] + 1'b1;
      end
      if (pop) rptr_d[p] = rptr_q[p] + 1'b1;
      cnt_d[p]  = cnt_q[p] + FCW'(push) - FCW'(pop);
      busy_d[p] = cnt_d[p] == FCW'(FIFO_DEPTH);
    end

    out_vld_d = out_vld_q;
    out_d     = out_q;
    out_src_d = out_src_q;
    rr_d      = rr_q;
    if (load_ok) begin
      if (win_vld) begin
        out_vld_d = 1'b1;
        out_d     = fifo_q[win][rptr_q[win]];
        out_src_d = win;
        rr_d      = (win == port_t'(N_PORTS - 1)) ?
                    '0 : win + 1'b1;
      end else begin
        out_vld_d = 1'b0;
        out_d     = '0;
        out_src_d = '0;
      end
    end

    tpush   = accept & ~out_q.is_wr;
    tpop    = bus.mem_rd_rdy & (tcnt_q != '0);
    tag_d   = tag_q;
    twp_d   = twp_q;
    trp_d   = trp_q;
    rdy_d   = '0;
    rdata_d = rdata_q;
    if (bus.mem_rd_rdy & (tcnt_q == '0)) err_d = 1'b1;
    if (tpush) begin
      tag_d[twp_q] = out_src_q;
      twp_d        = twp_q + 1'b1;
    end
    if (tpop) begin
      trp_d               = trp_q + 1'b1;
      rdy_d[tag_q[trp_q]] = 1'b1;
      rdata_d             = bus.mem_rdata;
    end
    tcnt_d = tcnt_q + TCW'(tpush) - TCW'(tpop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q    <= '{default: '0};
      wptr_q    <= '{default: '0};
      rptr_q    <= '{default: '0};
      cnt_q     <= '{default: '0};
      busy_q    <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
      out_src_q <= '0;
      rr_q      <= '0;
      tag_q     <= '{default: '0};
      twp_q     <= '0;
      trp_q     <= '0;
      tcnt_q    <= '0;
      rdy_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
      out_src_q <= out_src_d;
      rr_q      <= rr_d;
      tag_q     <= tag_d;
      twp_q     <= twp_d;
      trp_q     <= trp_d;
      tcnt_q    <= tcnt_d;
      rdy_q     <= rdy_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.up_busy        = busy_q;
  assign bus.up_rd_rdy      = rdy_q;
  assign bus.up_rdata       = rdata_q;
  assign bus.mem_wr_req     = out_vld_q & out_q.is_wr;
  assign bus.mem_rd_req     = out_vld_q & ~out_q.is_wr;
  assign bus.mem_addr       = out_q.addr;
  assign bus.mem_wdata      = out_q.wdata;
  assign bus.mem_wr_byte_en = out_q.be;
  assign bus.proto_err      = err_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed + random scoreboard bench.
// Port id is carried in address bits [31:28].
module tb_mem_req_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int FD = 4;
  localparam int MR = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(
    .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)
  ) bus ();

  mem_req_arbiter #(
    .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
    .FIFO_DEPTH(FD), .MAX_RD(MR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  typedef struct {
    int          port;
    logic [31:0] data;
  } rsp_t;

  cmd_t exp_cmd [NP][$];
  rsp_t exp_resp [$];
  int   rd_pending [$];
  int   grant_log [$];
  int   total = 0;
  int   bad = 0;
  int   seq = 0;
  int   n_cmd = 0;

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    total++;
    bad++;
    $display("FAIL %s actual=missing required=present", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_up();
    bus.up_wr_req     = '0;
    bus.up_rd_req     = '0;
    bus.up_addr       = '0;
    bus.up_wdata      = '0;
    bus.up_wr_byte_en = '0;
  endtask

  function automatic int pending_cmds();
    int s = 0;
    for (int p = 0; p < NP; p++) s += exp_cmd[p].size();
    return s;
  endfunction

  task automatic drive(int p, bit wr, logic [31:0] a,
                       logic [31:0] d, logic [3:0] be);
    cmd_t e;
    e.is_wr = wr;
    e.addr  = a;
    e.wdata = wr ? d : '0;
    e.be    = wr ? be : '0;
    bus.up_addr[p*AW +: AW]       = a;
    bus.up_wdata[p*DW +: DW]      = e.wdata;
    bus.up_wr_byte_en[p*BW +: BW] = e.be;
    if (wr) bus.up_wr_req[p] = 1'b1;
    else    bus.up_rd_req[p] = 1'b1;
    exp_cmd[p].push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_up();
    bus.mem_busy   = 1'b0;
    bus.mem_rd_rdy = 1'b0;
    for (int p = 0; p < NP; p++) exp_cmd[p].delete();
    rd_pending.delete();
    exp_resp.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_idle(string t);
    chk({t, "_busy"}, bus.up_busy, 0);
    chk({t, "_rdy"}, bus.up_rd_rdy, 0);
    chk({t, "_rdata"}, bus.up_rdata, 0);
    chk({t, "_wr"}, bus.mem_wr_req, 0);
    chk({t, "_rd"}, bus.mem_rd_req, 0);
    chk({t, "_addr"}, bus.mem_addr, 0);
    chk({t, "_wdata"}, bus.mem_wdata, 0);
    chk({t, "_be"}, bus.mem_wr_byte_en, 0);
    chk({t, "_err"}, bus.proto_err, 0);
  endtask

  task automatic ret(logic [31:0] d, int exp_port);
    rsp_t r;
    if (rd_pending.size() == 0) begin
      fail("ret_no_pending");
      return;
    end
    r.port = rd_pending.pop_front();
    r.data = d;
    exp_resp.push_back(r);
    bus.mem_rd_rdy = 1'b1;
    bus.mem_rdata  = d;
    tick();
    bus.mem_rd_rdy = 1'b0;
    chk("ret_port", bus.up_rd_rdy, 1 << exp_port);
    chk("ret_data", bus.up_rdata, d);
  endtask

  task automatic ctrl_step();
    rsp_t r;
    bus.mem_busy = ($urandom_range(0, 3) == 0);
    if (rd_pending.size() > 0 &&
        $urandom_range(0, 2) == 0) begin
      r.port = rd_pending.pop_front();
      r.data = $urandom;
      exp_resp.push_back(r);
      bus.mem_rd_rdy = 1'b1;
      bus.mem_rdata  = r.data;
    end else begin
      bus.mem_rd_rdy = 1'b0;
    end
  endtask

  task automatic drain(bit use_ctrl);
    int n = 0;
    idle_up();
    bus.mem_busy = 1'b0;
    while ((pending_cmds() != 0 || exp_resp.size() != 0 ||
            (use_ctrl && rd_pending.size() != 0)) &&
           n < 3000) begin
      if (use_ctrl) ctrl_step();
      tick();
      n++;
    end
    bus.mem_rd_rdy = 1'b0;
    bus.mem_busy   = 1'b0;
    tick();
    tick();
    chk("drain_cmd", pending_cmds(), 0);
    chk("drain_rsp", exp_resp.size() +
        (use_ctrl ? rd_pending.size() : 0), 0);
  endtask

  always @(negedge clk) begin
    int   p;
    cmd_t e;
    rsp_t r;
    if (!reset) begin
      if ((bus.mem_wr_req || bus.mem_rd_req) &&
          !bus.mem_busy) begin
        chk("req_onehot",
            bus.mem_wr_req ^ bus.mem_rd_req, 1);
        p = int'(bus.mem_addr[31:28]);
        grant_log.push_back(p);
        n_cmd++;
        if (p >= NP) begin
          fail("cmd_port_range");
        end else if (exp_cmd[p].size() == 0) begin
          fail("cmd_expected");
        end else begin
          e = exp_cmd[p].pop_front();
          chk("cmd_kind", bus.mem_wr_req, e.is_wr);
          chk("cmd_addr", bus.mem_addr, e.addr);
          chk("cmd_wdata", bus.mem_wdata, e.wdata);
          chk("cmd_be", bus.mem_wr_byte_en, e.be);
        end
        if (bus.mem_rd_req) rd_pending.push_back(p);
      end
      if (bus.up_rd_rdy != '0) begin
        chk("rsp_onehot", $onehot(bus.up_rd_rdy), 1);
        if (exp_resp.size() == 0) begin
          fail("rsp_expected");
        end else begin
          r = exp_resp.pop_front();
          chk("rsp_port", bus.up_rd_rdy, 1 << r.port);
          chk("rsp_data", bus.up_rdata, r.data);
        end
      end
    end
  end

  initial begin
    int n;
    int k;
    reset          = 1'b1;
    bus.mem_busy   = 1'b0;
    bus.mem_rd_rdy = 1'b0;
    bus.mem_rdata  = '0;
    idle_up();
    tick();
    tick();
    check_idle("rst");
    reset = 1'b0;

    drive(0, 1, 32'h100, 32'hDEADBEEF, 4'hF);
    tick();
    idle_up();
    tick();
    chk("sw_wr", bus.mem_wr_req, 1);
    chk("sw_rd", bus.mem_rd_req, 0);
    chk("sw_addr", bus.mem_addr, 32'h100);
    chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("sw_be", bus.mem_wr_byte_en, 4'hF);
    tick();
    chk("sw_one_cycle", bus.mem_wr_req, 0);

    do_reset();
    grant_log.delete();
    for (int r = 0; r < 2; r++) begin
      idle_up();
      for (int p = 0; p < NP; p++)
        drive(p, 1, {4'(p), 28'(r)}, $urandom, 4'hF);
      tick();
    end
    drain(0);
    chk("rr_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("rr_order", grant_log[i], i % NP);

    drive(2, 0, 32'h2000_0040, 0, 0);
    tick();
    idle_up();
    drive(1, 0, 32'h1000_0080, 0, 0);
    tick();
    idle_up();
    n = 0;
    while (rd_pending.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("rt_issued", rd_pending.size(), 2);
    ret(32'h11, 2);
    ret(32'h22, 1);
    drain(0);

    bus.mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_not_busy", bus.up_busy[0], 0);
      drive(0, 1, 32'h0000_5000 + i, $urandom, 4'hA);
      tick();
      idle_up();
    end
    chk("bp_full", bus.up_busy[0], 1);
    tick();
    tick();
    chk("bp_still_full", bus.up_busy[0], 1);
    chk("bp_hold_req", bus.mem_wr_req, 1);
    chk("bp_hold_addr", bus.mem_addr, 32'h0000_5000);
    bus.mem_busy = 1'b0;
    tick();
    chk("bp_busy_fall", bus.up_busy[0], 0);
    drive(0, 1, 32'h0000_5005, $urandom, 4'h5);
    tick();
    drain(0);

    k = 0;
    n = 0;
    while (k < MR + 1 && n < 100) begin
      idle_up();
      if (!bus.up_busy[3]) begin
        drive(3, 0, 32'h3000_0000 + k, 0, 0);
        k++;
      end
      tick();
      n++;
    end
    idle_up();
    tick();
    tick();
    tick();
    chk("rl_outstanding", rd_pending.size(), MR);
    chk("rl_held", exp_cmd[3].size(), 1);
    drive(0, 1, 32'h0000_0777, 32'h1234_5678, 4'hF);
    tick();
    idle_up();
    n = 0;
    while (exp_cmd[0].size() != 0 && n < 10) begin
      tick();
      n++;
    end
    chk("rl_wr_bypass", exp_cmd[0].size(), 0);
    chk("rl_rd_stalled", exp_cmd[3].size(), 1);
    ret($urandom, 3);
    n = 0;
    while (exp_cmd[3].size() != 0 && n < 10) begin
      tick();
      n++;
    end
    chk("rl_rd_release", exp_cmd[3].size(), 0);
    n = 0;
    while (rd_pending.size() > 0 && n < 20) begin
      ret($urandom, 3);
      n++;
    end
    drain(0);

    chk("err_clear", bus.proto_err, 0);
    drive(1, 1, 32'h1000_0001, 32'hCAFE_0001, 4'h3);
    bus.up_rd_req[1] = 1'b1;
    tick();
    idle_up();
    chk("err_wrrd", bus.proto_err, 1);
    drain(0);
    chk("err_sticky", bus.proto_err, 1);
    do_reset();
    chk("err_reset", bus.proto_err, 0);
    bus.mem_rd_rdy = 1'b1;
    bus.mem_rdata  = 32'h5555_5555;
    tick();
    bus.mem_rd_rdy = 1'b0;
    chk("err_spurious", bus.proto_err, 1);
    chk("err_no_rdy", bus.up_rd_rdy, 0);
    tick();
    tick();
    chk("err_sticky2", bus.proto_err, 1);

    do_reset();
    bus.mem_busy = 1'b1;
    for (int r = 0; r < 3; r++) begin
      idle_up();
      for (int p = 0; p < 3; p++)
        drive(p, 1, {4'(p), 28'(r + 16)}, $urandom, 4'hF);
      tick();
    end
    idle_up();
    tick();
    chk("mid_req", bus.mem_wr_req, 1);
    do_reset();
    check_idle("mid_rst");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_gone_wr", bus.mem_wr_req, 0);
      chk("mid_gone_rd", bus.mem_rd_req, 0);
    end

    do_reset();
    n_cmd = 0;
    for (int c = 0; c < 1500; c++) begin
      idle_up();
      for (int p = 0; p < NP; p++) begin
        if (!bus.up_busy[p] &&
            $urandom_range(0, 2) == 0) begin
          seq++;
          drive(p, 1'($urandom_range(0, 1)),
                {4'(p), 28'(seq)}, $urandom,
                4'($urandom_range(0, 15)));
        end
      end
      ctrl_step();
      tick();
    end
    drain(1);
    chk("rand_volume", n_cmd >= 100, 1);
    chk("rand_no_err", bus.proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised N-port front end for the HyperRAM memory controller bus. Each upstream port speaks the existing request protocol (addr, wr_req, rd_req, wdata, wr_byte_en, busy, rd_rdy, rdata) and owns a command FIFO. A round-robin arbiter issues commands to the single downstream controller port. Read data is routed back to the issuing port via an in-order tag queue. Sits between the DMA/CPU masters and the HyperRAM controller.

## Interface

Parameters:
- N_PORTS, 4: number of upstream ports (1..8)
- ADDR_W, 32: address width
- DATA_W, 32: data width, multiple of 8; byte-enable width BE_W = DATA_W/8
- FIFO_DEPTH, 4: per-port command FIFO depth, power of two ≥ 2
- MAX_RD, 8: max outstanding downstream reads, power of two ≥ 2

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- up_addr  in  N_PORTS*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W]
- up_wr_req  in  N_PORTS  per-port write request
- up_rd_req  in  N_PORTS  per-port read request
- up_wdata  in  N_PORTS*DATA_W  per-port write data
- up_wr_byte_en  in  N_PORTS*BE_W  per-port byte enables
- up_busy  out  N_PORTS  per-port FIFO full
- up_rd_rdy  out  N_PORTS  one-cycle read-data-valid pulse, one-hot or zero
- up_rdata  out  DATA_W  read data, shared, valid when any up_rd_rdy bit set
- mem_addr  out  ADDR_W  downstream address
- mem_wr_req  out  1  downstream write request
- mem_rd_req  out  1  downstream read request
- mem_wdata  out  DATA_W  downstream write data
- mem_wr_byte_en  out  BE_W  downstream byte enables
- mem_busy  in  1  controller cannot accept
- mem_rd_rdy  in  1  one-cycle read-data-valid pulse from controller
- mem_rdata  in  DATA_W  read data from controller
- proto_err  out  1  sticky protocol-error flag, cleared only by reset

## Operation

- Upstream accept: port p request accepted at an edge where (up_wr_req[p] | up_rd_req[p]) & !up_busy[p]; entry {is_wr, addr, wdata, be} pushed to FIFO p.
- up_wr_req[p] and up_rd_req[p] both high: write accepted, read dropped, proto_err set.
- up_busy[p] = FIFO p count == FIFO_DEPTH, registered from count; pop and push at full cannot coincide (busy blocks push).
- Downstream output register holds one command. Request lines stay asserted with stable addr/wdata/be until an edge with mem_busy low (accept). Exactly one of mem_wr_req/mem_rd_req high when valid.
- Arbitration when output register empty or accepted this edge: round-robin over non-empty FIFOs starting at rr_ptr; winner popped and loaded; rr_ptr <- winner+1 mod N_PORTS. No winner: register empties, requests low.
- A FIFO whose head is a read is ineligible while tag queue holds MAX_RD entries; other ports' writes still proceed.
- Tag queue: on downstream read accept, push port index. On mem_rd_rdy: pop, register up_rd_rdy[tag] and up_rdata <= mem_rdata. mem_rd_rdy with tag queue empty: ignored, proto_err set.
- Read push and mem_rd_rdy pop in same cycle: both occur, count unchanged.
- Ordering: per-port commands issue in acceptance order; reads complete in downstream issue order.

## Timing

- Reset: all FIFOs, tag queue, output register cleared; rr_ptr = 0; up_busy = 0, up_rd_rdy = 0, up_rdata = 0, mem_wr_req = mem_rd_req = 0, mem_addr/mem_wdata/mem_wr_byte_en = 0, proto_err = 0. Reset mid-operation discards queued and outstanding commands; downstream controller shares this reset.
- Upstream accept at edge E → mem_*_req high after edge E+1 when idle (1-cycle latency).
- Back-to-back: with mem_busy low, one command issued per cycle.
- mem_rd_rdy at edge E → up_rd_rdy[tag] high for the cycle after edge E.
- up_busy[p] rises the cycle after the accept that filled FIFO p; falls the cycle after the pop.
- Round-robin fairness: any non-empty eligible port is granted within N_PORTS grants.

## Test plan

- Single write: port 0 writes addr 0x100, data 0xDEADBEEF, be 0xF, mem_busy 0 → mem_wr_req one cycle later with those values, held 1 cycle.
- Fairness: ports 0–3 each queue 2 writes simultaneously → downstream order ports 0,1,2,3,0,1,2,3.
- Read routing: port 2 reads 0x40, port 1 reads 0x80; controller returns 0x11 then 0x22 → up_rd_rdy[2] with 0x11, then up_rd_rdy[1] with 0x22.
- Backpressure/full: mem_busy held 1, port 0 issues 6 writes (FIFO_DEPTH 4) → first in output register, 4 in FIFO, up_busy[0] high, 6th stalls; release → all 6 issue in order, none lost.
- Read limit: MAX_RD reads outstanding, port 3 head is a read, port 0 head is write → port 0 write issues, port 3 stalls until one mem_rd_rdy.
- Errors/reset: simultaneous wr_req+rd_req on port 1, or mem_rd_rdy with no outstanding read → proto_err 1 and stays 1; reset mid-burst → all outputs 0 next cycle, queued commands gone.
